// File: rtl/spi_read_sdc.sv
// spi_read_sdc: SPI-mode SD card single-block reader (CMD17) that streams 512 data bytes.
module spi_read_sdc #(
  parameter int R1_TIMEOUT    = 8,
  parameter int TOKEN_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic        i_miso,
  output logic        o_mosi,
  output logic        o_cs,
  output logic        o_sck_en,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);
  typedef enum logic [2:0] {IDLE, CMD, R1_WAIT, R1_RX, TOKEN, DATA, CRC, POST} state_t;
  state_t      state;
  logic [46:0] sr;
  logic [15:0] cnt;
  logic [2:0]  bc;
  logic [8:0]  byte_cnt;
  logic [7:0]  rx;
  logic [47:0] cmd_frame;
  logic [1:0]  err_nxt;
  logic        byte_end, go_post;
  assign cmd_frame = {8'h51, i_addr, 8'hFF};
  assign rx = {sr[6:0], i_miso};
  assign byte_end = bc == 3'd7;
  always_comb begin
    err_nxt = (state == R1_WAIT && i_miso && cnt == 16'(R1_TIMEOUT * 8 - 1)) ? 2'd1 :
              (state == R1_RX && byte_end && rx != 8'h00) ? 2'd2 :
              (state == TOKEN && byte_end &&
               (rx == 8'hFF ? cnt == 16'(TOKEN_TIMEOUT - 1) : rx != 8'hFE)) ? 2'd3 : 2'd0;
    go_post = err_nxt != 2'd0 || (state == CRC && cnt == 16'd15);
  end
  // sr shifts MISO in every cycle; during CMD its upper bits still hold the unsent frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      bc         <= '0;
      byte_cnt   <= '0;
      o_mosi     <= 1'b1;
      o_cs       <= 1'b1;
      o_sck_en   <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= '0;
    end else begin
      sr      <= {sr[45:0], i_miso};
      cnt     <= cnt + 16'd1;
      bc      <= bc + 3'd1;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= err_nxt != 2'd0;
      if (err_nxt != 2'd0) o_err_code <= err_nxt;
      case (state)
        IDLE: if (i_start) begin
          state      <= CMD;
          sr         <= cmd_frame[46:0];
          o_mosi     <= cmd_frame[47];
          cnt        <= '0;
          o_cs       <= 1'b0;
          o_sck_en   <= 1'b1;
          o_busy     <= 1'b1;
          o_err_code <= '0;
        end
        CMD: begin
          o_mosi <= cnt == 16'd47 ? 1'b1 : sr[46];
          if (cnt == 16'd47) begin
            state <= R1_WAIT;
            cnt   <= '0;
          end
        end
        R1_WAIT: if (!i_miso) begin
          state <= R1_RX;
          bc    <= 3'd1;
        end
        R1_RX: if (byte_end && rx == 8'h00) begin
          state <= TOKEN;
          cnt   <= '0;
        end
        TOKEN: begin
          cnt <= cnt + {15'd0, byte_end};
          if (byte_end && rx == 8'hFE) begin
            state    <= DATA;
            byte_cnt <= '0;
          end
        end
        DATA: if (byte_end) begin
          o_data   <= rx;
          o_valid  <= 1'b1;
          byte_cnt <= byte_cnt + 9'd1;
          if (byte_cnt == 9'd511) begin
            state <= CRC;
            cnt   <= '0;
          end
        end
        POST: if (cnt == 16'd7) begin
          state    <= IDLE;
          o_sck_en <= 1'b0;
          o_busy   <= 1'b0;
          o_done   <= o_err_code == 2'd0;
        end
        default: ;
      endcase
      if (go_post) begin
        state  <= POST;
        cnt    <= '0;
        o_cs   <= 1'b1;
        o_mosi <= 1'b1;
      end
    end
  end
endmodule

// File: doc/spi_read_sdc.md
SPI_READ_SDC -- requirements
Module: spi_read_sdc

Interface
REQ-001 Parameter R1_TIMEOUT, default 8: max response bytes clocked while waiting for the R1 start bit.
REQ-002 Parameter TOKEN_TIMEOUT, default 1024: max 0xFF bytes clocked while waiting for the data token.
REQ-003 i_clk  in  1  SPI bit clock; one bit per cycle; all logic on rising edge.
REQ-004 i_rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-005 i_start  in  1  one-cycle request to read one 512-byte block.
REQ-006 i_addr  in  32  block address, sent unmodified as the CMD17 argument.
REQ-007 i_miso  in  1  card data out.
REQ-008 o_mosi  out  1  card data in.
REQ-009 o_cs  out  1  card chip select, active-low.
REQ-010 o_sck_en  out  1  SCK gate; top drives SCK = ~i_clk while high, 0 otherwise.
REQ-011 o_data  out  8  received data byte.
REQ-012 o_valid  out  1  one-cycle strobe qualifying o_data.
REQ-013 o_busy  out  1  high from accepted start until return to IDLE.
REQ-014 o_done  out  1  one-cycle pulse: block read completed without error.
REQ-015 o_err  out  1  one-cycle pulse: read aborted.
REQ-016 o_err_code  out  2  1=R1 timeout, 2=R1 nonzero, 3=token timeout or error token; holds until next accepted start.

Function
REQ-017 States: IDLE, CMD, R1_WAIT, R1_RX, TOKEN, DATA, CRC, POST; register updates only on rising i_clk.
REQ-018 IDLE: o_cs=1, o_mosi=1, o_sck_en=0, o_busy=0; i_start=1 latches i_addr and enters CMD next cycle.
REQ-019 i_start while o_busy=1 is ignored; no queuing.
REQ-020 CMD: o_cs=0, o_sck_en=1, shift 48 bits MSB first: 0x51, i_addr[31:24], [23:16], [15:8], [7:0], 0xFF; first bit on o_mosi the cycle after start accepted.
REQ-021 Outside CMD, o_mosi=1 whenever o_sck_en=1.
REQ-022 R1_WAIT: sample i_miso each cycle; first 0 sample enters R1_RX with that bit as R1 bit 7; R1_TIMEOUT*8 cycles without a 0 -> error code 1.
REQ-023 R1_RX: collect 7 more bits; R1=0x00 -> TOKEN; R1 nonzero -> error code 2.
REQ-024 TOKEN: receive byte-aligned to R1 end; 0xFF continues; 0xFE -> DATA; any other byte or TOKEN_TIMEOUT 0xFF bytes -> error code 3.
REQ-025 DATA: 512 bytes MSB first; o_valid=1 for exactly one cycle, in the cycle after the 8th bit of each byte is sampled, with o_data stable that cycle; byte counter 9 bits, exits after count 511.
REQ-026 CRC: clock 16 bits, discard, no check.
REQ-027 POST: o_cs=1, o_sck_en=1, o_mosi=1 for 8 cycles, then IDLE; o_done pulses on the IDLE-entry cycle if no error.
REQ-028 Any error: o_err pulses one cycle on detection, o_err_code set same cycle, go to POST; o_done not asserted for that transaction.
REQ-029 Exactly 512 o_valid pulses per successful read; none after an error.
REQ-030 o_busy deasserts the same cycle o_done/o_err-terminated transaction reaches IDLE.

Reset
REQ-031 i_rst=1 at a rising edge forces IDLE regardless of state: o_cs=1, o_mosi=1, o_sck_en=0, o_valid=0, o_busy=0, o_done=0, o_err=0, o_err_code=0, all counters 0.
REQ-032 Reset mid-transaction aborts without o_done or o_err; the first i_start after reset is accepted normally.

Verification
REQ-033 Card model responds R1=0x00 after 3 0xFF bytes, token after 10 0xFF bytes, data bytes 0x00..0xFF repeated, addr 0x00001234 -> MOSI frame 51 00 00 12 34 FF, 512 o_valid with matching bytes, o_done once, o_err never.
REQ-034 Card never drives MISO low (all 1s) -> o_err with code 1 after 64 R1_WAIT cycles, then 8 POST cycles with o_cs=1, IDLE.
REQ-035 Card returns R1=0x05 -> o_err code 2, no o_valid, o_done=0.
REQ-036 Card returns R1=0x00 then token byte 0x0B -> o_err code 3; separately 1024 0xFF bytes -> o_err code 3.
REQ-037 Reset asserted after 100 data bytes -> next cycle all outputs at reset values; new i_start completes full read correctly.
REQ-038 i_start pulsed repeatedly during DATA -> ignored; exactly one frame sent, 512 o_valid.
